// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
// Owns the fetch PC, the per-stage valid bits and the allowin chain, and
// runs the trap FSM that drains the pipe on ecall before jumping to mtvec.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is
// defined; otherwise cycle_cnt/stall_cnt are tied to zero.
//
// Trap FSM states:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | normal flow; fetch enabled unless ID holds an ecall
//   ST_DRAIN | ecall held in ID, fetch stopped, waiting for EX/MEM/WB empty
//   ST_TRAP  | one cycle: strobe mepc/mcause write, redirect to mtvec
module pipe_ctrl #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_inst_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] ds_pc,
  output logic            ds_valid,
  output logic            es_valid,
  output logic            ms_valid,
  output logic            ws_valid,
  output logic            ds_allowin,
  input  logic            load_use_stall,
  input  logic            ecall_flag,
  input  logic            ex_busy,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] mtvec_in,
  output logic            csr_trap_we,
  output logic [XLEN-1:0] mepc_out,
  output logic            trap_busy,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t state;

  logic ds_ready_go;
  logic es_ready_go;
  logic ws_allowin;
  logic ms_allowin;
  logic es_allowin;
  logic fetch_en;
  logic br_fire;
  logic trap_fire;
  logic kill_young;

  // Handshake terms: ready_go per stage, allowin chain from WB back to ID.
  always_comb begin
    ds_ready_go = !load_use_stall && !(ecall_flag && ds_valid);
    es_ready_go = !ex_busy;
    ws_allowin  = 1'b1;
    ms_allowin  = !ms_valid || ws_allowin;
    es_allowin  = !es_valid || (es_ready_go && ms_allowin);
    ds_allowin  = !ds_valid || (ds_ready_go && es_allowin);
    fetch_en    = (state == ST_IDLE) && !(ecall_flag && ds_valid);
    // A busy EX has not finished resolving, so its branch waits.
    br_fire     = es_valid && es_ready_go && br_taken;
    trap_fire   = (state == ST_TRAP);
    // Everything younger than the redirecting instruction is wrong-path.
    kill_young  = br_fire || trap_fire;
  end

  // Stage valid bits, ID PC and fetch PC with redirect priority trap > branch > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out   <= RESET_PC;
      ds_pc    <= '0;
      ds_valid <= 1'b0;
      es_valid <= 1'b0;
      ms_valid <= 1'b0;
      ws_valid <= 1'b0;
    end else begin
      ws_valid <= ms_valid;
      if (ms_allowin) ms_valid <= es_valid && es_ready_go;
      if (es_allowin) es_valid <= ds_valid && ds_ready_go && !kill_young;
      if (kill_young) begin
        ds_valid <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid <= if_inst_valid && fetch_en;
      end
      if (ds_allowin) ds_pc <= pc_out;
      if (trap_fire) begin
        pc_out <= mtvec_in;
      end else if (br_fire) begin
        pc_out <= br_target;
      end else if (if_inst_valid && ds_allowin && fetch_en) begin
        pc_out <= pc_out + PC_STEP;
      end
    end
  end

  // Trap FSM: hold the ecall in ID until older work retires, then one TRAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      csr_trap_we <= 1'b0;
      mepc_out    <= '0;
    end else begin
      csr_trap_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A same-cycle older branch flushes the ecall before it can trap.
          if (ds_valid && ecall_flag && !br_fire) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (br_fire) begin
            state <= ST_IDLE;
          end else if (!es_valid && !ms_valid && !ws_valid) begin
            state       <= ST_TRAP;
            csr_trap_we <= 1'b1;
            mepc_out    <= ds_pc;
          end
        end
        ST_TRAP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign trap_busy = (state != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] stall_q;

  // Free-running cycle counter and ID stall counter, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (ds_valid && !ds_ready_go) stall_q <= stall_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: table of per-cycle stimulus and expected outputs,
// routed through a scoreboard queue, plus a short counter sequence.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_inst_valid;
  logic [31:0] pc_out;
  logic [31:0] ds_pc;
  logic        ds_valid, es_valid, ms_valid, ws_valid;
  logic        ds_allowin;
  logic        load_use_stall;
  logic        ecall_flag;
  logic        ex_busy;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] mtvec_in;
  logic        csr_trap_we;
  logic [31:0] mepc_out;
  logic        trap_busy;
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_inst_valid  (if_inst_valid),
    .pc_out         (pc_out),
    .ds_pc          (ds_pc),
    .ds_valid       (ds_valid),
    .es_valid       (es_valid),
    .ms_valid       (ms_valid),
    .ws_valid       (ws_valid),
    .ds_allowin     (ds_allowin),
    .load_use_stall (load_use_stall),
    .ecall_flag     (ecall_flag),
    .ex_busy        (ex_busy),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .mtvec_in       (mtvec_in),
    .csr_trap_we    (csr_trap_we),
    .mepc_out       (mepc_out),
    .trap_busy      (trap_busy),
    .cycle_cnt      (cycle_cnt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        lus;
    logic        ec;
    logic        busy;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] mtv;
    logic [31:0] pc;
    logic [31:0] dspc;
    logic [3:0]  v;      // {ds, es, ms, ws}
    logic        al;
    logic        we;
    logic [31:0] mepc;
    logic        tb;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rs, iv, lus, ec, busy, br,
                     input logic [31:0] tgt, mtv, pc, dspc,
                     input logic [3:0] v, input logic al, we,
                     input logic [31:0] mepc, input logic tb);
    vec_t r;
    r.rst = rs; r.iv = iv; r.lus = lus; r.ec = ec; r.busy = busy; r.br = br;
    r.tgt = tgt; r.mtv = mtv; r.pc = pc; r.dspc = dspc; r.v = v; r.al = al;
    r.we = we; r.mepc = mepc; r.tb = tb;
    vecs.push_back(r);
  endtask

  task automatic add_reset();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
  endtask

  // Free-flowing fetch straight out of reset: PC steps by 4, pipe fills.
  task automatic add_stream(input int n, input logic [31:0] mtv);
    logic [3:0] v;
    for (int k = 0; k < n; k++) begin
      case (k)
        0: v = 4'b0000;
        1: v = 4'b1000;
        2: v = 4'b1100;
        3: v = 4'b1110;
        default: v = 4'b1111;
      endcase
      add(0, 1, 0, 0, 0, 0, 0, mtv, 32'(4 * k), (k == 0) ? 32'h0 : 32'(4 * (k - 1)),
          v, 1, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_inst_valid = 0; load_use_stall = 0; ecall_flag = 0;
    ex_busy = 0; br_taken = 0; br_target = 0; mtvec_in = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check32("rst_pc", pc_out, 32'h0);
    check32("rst_dspc", ds_pc, 32'h0);
    check32("rst_valid", {28'h0, ds_valid, es_valid, ms_valid, ws_valid}, 32'h0);
    check32("rst_we", {31'h0, csr_trap_we}, 32'h0);
    check32("rst_mepc", mepc_out, 32'h0);
    check32("rst_tbusy", {31'h0, trap_busy}, 32'h0);
  endtask

  initial begin
    vec_t v;
    vec_t e;
    // Fill from reset: PC 0,4,8,12; ws first valid on cycle 4.
    add_reset();
    add_stream(5, 0);
    // One-cycle load-use stall with ID at 0x8.
    add_reset();
    add_stream(3, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 32'hC, 32'h8, 4'b1110, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'hC, 32'h8, 4'b1011, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 32'hC, 4'b1101, 1, 0, 0, 0);
    // Taken branch from EX at 0x4 to 0x100.
    add_reset();
    add_stream(3, 0);
    add(0, 1, 0, 0, 0, 1, 32'h100, 0, 32'hC, 32'h8, 4'b1110, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h100, 32'hC, 4'b0011, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h104, 32'h100, 4'b1001, 1, 0, 0, 0);
    // Branch to the top of the address space; PC wraps to 0.
    add_reset();
    add_stream(3, 0);
    add(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'hC, 32'h8, 4'b1110, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hC, 4'b0011, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 4'b1001, 1, 0, 0, 0);
    // Ecall at 0x20 with three older instructions in flight, mtvec 0x80.
    add_reset();
    add_stream(9, 32'h80);
    add(0, 1, 0, 1, 0, 0, 0, 32'h80, 32'h24, 32'h20, 4'b1111, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 32'h80, 32'h24, 32'h20, 4'b1011, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0, 32'h80, 32'h24, 32'h20, 4'b1001, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0, 32'h80, 32'h24, 32'h20, 4'b1000, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0, 32'h80, 32'h24, 32'h20, 4'b1000, 0, 1, 32'h20, 1);
    add(0, 1, 0, 0, 0, 0, 0, 32'h80, 32'h80, 32'h20, 4'b0000, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 32'h80, 32'h84, 32'h80, 4'b1000, 1, 0, 0, 0);
    // Reset while draining for an ecall, then normal restart.
    add_reset();
    add_stream(2, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 32'h8, 32'h4, 4'b1100, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 32'h8, 32'h4, 4'b1010, 0, 0, 0, 1);
    add_reset();
    add_stream(2, 0);
    // Ecall in ID behind a busy EX branch; branch resolves in DRAIN and wins.
    add_reset();
    add_stream(2, 0);
    add(0, 1, 0, 1, 1, 1, 32'h40, 0, 32'h8, 32'h4, 4'b1100, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 32'h40, 0, 32'h8, 32'h4, 4'b1100, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h40, 32'h4, 4'b0010, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h44, 32'h40, 4'b1001, 1, 0, 0, 0);
    // EX busy for three cycles: three MEM bubbles, ID blocked.
    add_reset();
    add_stream(3, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 32'hC, 32'h8, 4'b1110, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 32'hC, 32'h8, 4'b1101, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 32'hC, 32'h8, 4'b1100, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'hC, 32'h8, 4'b1100, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 32'hC, 4'b1110, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) begin
        do_reset();
      end else begin
        if_inst_valid = v.iv; load_use_stall = v.lus; ecall_flag = v.ec;
        ex_busy = v.busy; br_taken = v.br; br_target = v.tgt; mtvec_in = v.mtv;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check32($sformatf("pc[%0d]", i), pc_out, e.pc);
        check32($sformatf("dspc[%0d]", i), ds_pc, e.dspc);
        check32($sformatf("valid[%0d]", i), {28'h0, ds_valid, es_valid, ms_valid, ws_valid},
                {28'h0, e.v});
        check32($sformatf("allowin[%0d]", i), {31'h0, ds_allowin}, {31'h0, e.al});
        check32($sformatf("trap_we[%0d]", i), {31'h0, csr_trap_we}, {31'h0, e.we});
        check32($sformatf("tbusy[%0d]", i), {31'h0, trap_busy}, {31'h0, e.tb});
        if (e.we) check32($sformatf("mepc[%0d]", i), mepc_out, e.mepc);
        @(posedge clk);
        #1;
      end
    end

    // Counters: 5 cycles of streaming with a 2-cycle load-use stall in ID.
    do_reset();
`ifdef PIPE_CTRL_PERF_EN
    check32("cyc_rst", cycle_cnt, 32'd0);
    check32("stall_rst", stall_cnt, 32'd0);
    for (int c = 0; c < 5; c++) begin
      if_inst_valid = 1'b1;
      load_use_stall = (c == 2 || c == 3);
      @(posedge clk);
      #1;
    end
    check32("cyc_cnt", cycle_cnt, 32'd5);
    check32("stall_cnt", stall_cnt, 32'd2);
`else
    for (int c = 0; c < 5; c++) begin
      if_inst_valid = 1'b1;
      load_use_stall = (c == 2 || c == 3);
      @(posedge clk);
      #1;
    end
    check32("cyc_off", cycle_cnt, 32'd0);
    check32("stall_off", stall_cnt, 32'd0);
`endif
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
